// File: rtl/arbiter_ctrl.sv
// Shared arbiter control types: FSM states, client ids and the captured
// downstream request record.
package arbiter_ctrl;

   localparam int LINE_W   = 256;
   localparam int ADDR_W   = 32;
   localparam int OFFSET_W = 5;

   typedef enum logic [1:0] {
      IDLE,
      BUSY_I,
      BUSY_D,
      RESP
   } arb_state_t;

   typedef enum logic {
      CLIENT_I,
      CLIENT_D
   } arb_client_t;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [LINE_W-1:0] wdata;
      logic              read;
      logic              write;
   } arb_req_t;

   // Line-align an address by clearing the offset bits.
   function automatic logic [ADDR_W-1:0] line_addr(input logic [ADDR_W-1:0] a);
      return a & ~ADDR_W'((1 << OFFSET_W) - 1);
   endfunction

endpackage

// File: rtl/arb_req_capture.sv
// Load-enabled holding register for the granted request; its contents drive
// the downstream line port for the whole transaction.
module arb_req_capture
   import arbiter_ctrl::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic [ADDR_W-1:0] load_addr,
   input  logic [LINE_W-1:0] load_wdata,
   input  logic              load_read,
   input  logic              load_write,
   output logic [ADDR_W-1:0] addr,
   output logic [LINE_W-1:0] wdata,
   output logic              read,
   output logic              write
);

   arb_req_t req_q;
   arb_req_t req_d;

   assign req_d = '{addr: load_addr, wdata: load_wdata, read: load_read, write: load_write};

   always_ff @(posedge clk) begin
      if (rst) begin
         req_q <= '0;
      end else if (load) begin
         req_q <= req_d;
      end
   end

   assign addr  = req_q.addr;
   assign wdata = req_q.wdata;
   assign read  = req_q.read;
   assign write = req_q.write;

endmodule

// File: rtl/cache_arbiter.sv
// Round-robin arbiter between the I-cache and D-cache miss ports and the
// single line port toward L2 / physical memory.
module cache_arbiter #(
   parameter int LINE_W   = 256,
   parameter int ADDR_W   = 32,
   parameter int OFFSET_W = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_mem_read,
   input  logic [ADDR_W-1:0] i_mem_addr,
   output logic              i_mem_resp,
   output logic [LINE_W-1:0] i_mem_rdata,
   input  logic              d_mem_read,
   input  logic              d_mem_write,
   input  logic [ADDR_W-1:0] d_mem_addr,
   input  logic [LINE_W-1:0] d_mem_wdata,
   output logic              d_mem_resp,
   output logic [LINE_W-1:0] d_mem_rdata,
   output logic              mem_read,
   output logic              mem_write,
   output logic [ADDR_W-1:0] mem_address,
   output logic [LINE_W-1:0] mem_wdata,
   input  logic              mem_resp,
   input  logic [LINE_W-1:0] mem_rdata
);
   import arbiter_ctrl::*;

   arb_state_t  state_q;
   arb_state_t  state_d;
   arb_client_t last_grant_q;
   arb_client_t grant;

   logic              i_pend;
   logic              d_pend;
   logic              load;
   logic              busy;
   logic [ADDR_W-1:0] cap_addr;
   logic [LINE_W-1:0] cap_wdata;
   logic              cap_read;
   logic              cap_write;
   logic              req_read;
   logic              req_write;
   logic [LINE_W-1:0] i_line_q;
   logic [LINE_W-1:0] d_line_q;

   assign i_pend = i_mem_read;
   assign d_pend = d_mem_read | d_mem_write;

   // On a tie the client that did not win last time is served.
   always_comb begin
      grant = CLIENT_I;
      if (d_pend && (!i_pend || last_grant_q == CLIENT_I)) begin
         grant = CLIENT_D;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (i_pend || d_pend) begin
               state_d = (grant == CLIENT_D) ? BUSY_D : BUSY_I;
            end
         end
         BUSY_I, BUSY_D: begin
            if (mem_resp) begin
               state_d = RESP;
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      load       = 1'b0;
      busy       = 1'b0;
      i_mem_resp = 1'b0;
      d_mem_resp = 1'b0;
      case (state_q)
         IDLE:           load = i_pend | d_pend;
         BUSY_I, BUSY_D: busy = 1'b1;
         RESP: begin
            i_mem_resp = (last_grant_q == CLIENT_I);
            d_mem_resp = (last_grant_q == CLIENT_D);
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         last_grant_q <= CLIENT_I;
      end else if (load) begin
         last_grant_q <= grant;
      end
   end

   // A simultaneous D read+write is a write-back; the read is dropped.
   always_comb begin
      if (grant == CLIENT_D) begin
         cap_addr  = line_addr(d_mem_addr);
         cap_wdata = d_mem_wdata;
         cap_read  = d_mem_read & ~d_mem_write;
         cap_write = d_mem_write;
      end else begin
         cap_addr  = line_addr(i_mem_addr);
         cap_wdata = '0;
         cap_read  = 1'b1;
         cap_write = 1'b0;
      end
   end

   arb_req_capture u_req_capture (
      .clk        (clk),
      .rst        (rst),
      .load       (load),
      .load_addr  (cap_addr),
      .load_wdata (cap_wdata),
      .load_read  (cap_read),
      .load_write (cap_write),
      .addr       (mem_address),
      .wdata      (mem_wdata),
      .read       (req_read),
      .write      (req_write)
   );

   // Strobes follow the held request only while the transaction is open.
   assign mem_read  = req_read & busy;
   assign mem_write = req_write & busy;

   always_ff @(posedge clk) begin
      if (rst) begin
         i_line_q <= '0;
         d_line_q <= '0;
      end else if (mem_resp) begin
         if (state_q == BUSY_I) i_line_q <= mem_rdata;
         if (state_q == BUSY_D) d_line_q <= mem_rdata;
      end
   end

   assign i_mem_rdata = i_line_q;
   assign d_mem_rdata = d_line_q;

endmodule

// File: doc/cache_arbiter.md
Name: cache_arbiter

Overview:
- Two-client arbiter between the I-cache (read-only) and D-cache (read/write) miss ports and the single 256-bit line port toward L2/physical memory.
- Captures one client request, holds it stable on the downstream port until mem_resp, then returns the line to the owning client with a one-cycle resp pulse.
- Sits directly upstream of the memory-side pipeline register, which carries mem_wdata/mem_address/mem_read/mem_write and returns mem_rdata/mem_resp.

Parameters:
- LINE_W, 256, cache line width in bits
- ADDR_W, 32, address width in bits
- OFFSET_W, 5, line-offset bits, forced to zero on the downstream address

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- i_mem_read  in  1  I-cache line read request
- i_mem_addr  in  ADDR_W  I-cache request address
- i_mem_resp  out  1  one-cycle completion pulse to I-cache
- i_mem_rdata  out  LINE_W  line returned to I-cache
- d_mem_read  in  1  D-cache line read request
- d_mem_write  in  1  D-cache line write-back request
- d_mem_addr  in  ADDR_W  D-cache request address
- d_mem_wdata  in  LINE_W  D-cache write-back line
- d_mem_resp  out  1  one-cycle completion pulse to D-cache
- d_mem_rdata  out  LINE_W  line returned to D-cache
- mem_read  out  1  downstream read strobe
- mem_write  out  1  downstream write strobe
- mem_address  out  ADDR_W  downstream line address, low OFFSET_W bits zero
- mem_wdata  out  LINE_W  downstream write data
- mem_resp  in  1  downstream completion
- mem_rdata  in  LINE_W  downstream read data, valid when mem_resp=1

Behaviour:
- FSM states: IDLE, BUSY_I, BUSY_D, RESP. Reset state is IDLE.
- Reset values: all outputs 0, captured request registers 0, last_grant=I.
- Reset mid-transaction: FSM returns to IDLE and the in-flight transaction is dropped. mem_read/mem_write are 0 in the cycle after rst is sampled. No resp pulse is generated.
- IDLE, request sampling:
  - I request is pending when i_mem_read=1.
  - D request is pending when d_mem_read=1 or d_mem_write=1.
  - Only one pending: grant it.
  - Both pending: grant the client opposite last_grant (round-robin). After reset, D wins the first tie.
- On grant, at the clock edge:
  - Capture address (offset bits zeroed), op, and wdata (D only; I wdata is 0).
  - Update last_grant.
  - Go to BUSY_I or BUSY_D.
- d_mem_read and d_mem_write both 1: treated as a write; the read is ignored.
- BUSY_x:
  - mem_read/mem_write/mem_address/mem_wdata are driven only from the captured registers, never combinationally from client inputs. They stay constant until mem_resp=1 is sampled.
  - Client inputs changing or dropping during BUSY are ignored; the transaction completes and the resp pulse is still issued.
- On mem_resp=1 in BUSY_x:
  - Capture mem_rdata (writes capture it too, value irrelevant).
  - Deassert mem_read/mem_write in the next cycle.
  - Go to RESP.
- RESP (exactly one cycle):
  - x_mem_resp=1 and x_mem_rdata=captured line for the owner only; the other client's resp stays 0.
  - Then go to IDLE.
  - Requests are not sampled in RESP; the client drops its request in this cycle.
- x_mem_rdata holds its last captured value outside RESP. Clients treat it as valid only with resp.
- mem_resp while IDLE or RESP: ignored.
- Latency:
  - Request first seen in IDLE at edge N; mem_read/write high from cycle N+1.
  - mem_resp seen at edge M; client resp high in cycle M+1.
  - Earliest next grant is sampled at edge M+2.
- mem_read and mem_write are never 1 simultaneously.

Decomposition:
- Extend the shared arbiter_ctrl package:
  - enum arb_state_t {IDLE, BUSY_I, BUSY_D, RESP}
  - enum arb_client_t {CLIENT_I, CLIENT_D}
  - struct arb_req_t {addr, wdata, read, write}
  - constants LINE_W and OFFSET_W
- Sub-module arb_req_capture: a load-enabled register for arb_req_t with synchronous reset. It feeds the downstream port. The FSM stays in the top module.

Test Plan:
- Single I read: i_mem_read=1, i_mem_addr=0x0000_1234. Expected: next cycle mem_read=1, mem_address=0x0000_1220. After mem_resp with rdata=0xA5..A5: i_mem_resp pulses 1 cycle, i_mem_rdata=0xA5..A5, d_mem_resp=0.
- D write-back: d_mem_write=1, d_mem_addr=0x8000_0040, wdata=0xDEAD..BEEF. Expected: mem_write=1, mem_wdata matches, mem_read=0. mem_resp after a 5-cycle delay → d_mem_resp 1-cycle pulse.
- Tie after reset: i and d requests asserted in the same cycle. Expected: D granted first, then I. On a second simultaneous tie, D is granted again because last_grant is now I.
- Client drops request mid-BUSY: deassert d_mem_read 2 cycles into BUSY. Expected: mem_read stays 1 until mem_resp, and d_mem_resp still pulses.
- Reset during BUSY_I with mem_resp never given. Expected: next cycle all outputs 0 and state IDLE. A subsequent I request is granted normally.
- Illegal d_mem_read=1 and d_mem_write=1. Expected: mem_write=1, mem_read=0. Also a stray mem_resp pulse in IDLE produces no client resp.
